// File: rtl/div_32_5_recon.sv
// Multiply-back path for the divide-by-5 datapath: rebuilds X = 5*Q + R in a two-stage
// valid/ready pipeline and flags quotient/remainder pairs no 32-bit dividend can produce.
module div_32_5_recon (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [29:0] Q,
   input  logic [2:0]  R,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] X,
   output logic        err_rem,
   output logic        err_ovf,
   output logic [15:0] err_cnt
);

   logic        s1_v_q, s1_v_d;
   logic [32:0] p_q, p_d;
   logic [2:0]  r1_q, r1_d;
   logic        rem_bad_q, rem_bad_d;
   logic        s2_v_q, s2_v_d;
   logic [31:0] x_q, x_d;
   logic        err_rem_q, err_rem_d;
   logic        err_ovf_q, err_ovf_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   logic        accept, deliver, s2_load;
   logic [32:0] sum;

   // Stage 1 can take a new pair whenever it is empty or is handing off this cycle.
   assign s2_load  = s1_v_q && (!s2_v_q || out_ready);
   assign in_ready = !s1_v_q || !s2_v_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign deliver  = s2_v_q && out_ready;
   assign sum      = p_q + {30'd0, r1_q};

   always_comb begin
      s1_v_d    = s1_v_q;
      p_d       = p_q;
      r1_d      = r1_q;
      rem_bad_d = rem_bad_q;
      s2_v_d    = s2_v_q;
      x_d       = x_q;
      err_rem_d = err_rem_q;
      err_ovf_d = err_ovf_q;
      err_cnt_d = err_cnt_q;

      if (accept) begin
         s1_v_d    = 1'b1;
         p_d       = {1'b0, Q, 2'b00} + {3'd0, Q};
         r1_d      = R;
         rem_bad_d = (R > 3'd4);
      end else if (s2_load) begin
         s1_v_d = 1'b0;
      end

      if (s2_load) begin
         s2_v_d    = 1'b1;
         x_d       = sum[31:0];
         err_ovf_d = sum[32];
         err_rem_d = rem_bad_q;
      end else if (deliver) begin
         s2_v_d = 1'b0;
      end

      if (deliver && (err_rem_q || err_ovf_q) && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q    <= 1'b0;
         p_q       <= '0;
         r1_q      <= '0;
         rem_bad_q <= 1'b0;
         s2_v_q    <= 1'b0;
         x_q       <= '0;
         err_rem_q <= 1'b0;
         err_ovf_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         s1_v_q    <= s1_v_d;
         p_q       <= p_d;
         r1_q      <= r1_d;
         rem_bad_q <= rem_bad_d;
         s2_v_q    <= s2_v_d;
         x_q       <= x_d;
         err_rem_q <= err_rem_d;
         err_ovf_q <= err_ovf_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign out_valid = s2_v_q;
   assign X         = x_q;
   assign err_rem   = err_rem_q;
   assign err_ovf   = err_ovf_q;
   assign err_cnt   = err_cnt_q;

endmodule
